// File: rtl/wb_pwm_if.sv
// Pipelined Wishbone bus bundle for register access; clock and reset travel with the bus.
interface wishbone_p_if (
   input logic clk_i,
   input logic rst_i
);
   logic        cyc;
   logic        stb;
   logic        we;
   logic [31:0] adr;
   logic [31:0] dat_i;
   logic [31:0] dat_o;
   logic [3:0]  sel;
   logic        ack;
   logic        stall;

   modport master (
      input  clk_i, rst_i,
      output cyc, stb, we, adr, dat_i, sel,
      input  dat_o, ack, stall
   );

   modport slave (
      input  clk_i, rst_i,
      input  cyc, stb, we, adr, dat_i, sel,
      output dat_o, ack, stall
   );
endinterface

// File: rtl/wb_pwm.sv
// Multi-channel PWM generator with a zero-wait-state Wishbone register port.
// Define WB_PWM_SHADOW_EN to double-buffer PERIOD/DUTY until the period wraps.
module wb_pwm #(
   parameter int unsigned PORT_CNT  = 8,
   parameter int unsigned CNT_WIDTH = 16
) (
   wishbone_p_if.slave          wb,
   output logic [PORT_CNT-1:0]  pwm_out
);

   if (PORT_CNT < 1 || PORT_CNT > 8) begin : g_bad_port_cnt
      $fatal(1, "wb_pwm: PORT_CNT must be in [1,8]");
   end
   if (CNT_WIDTH < 1 || CNT_WIDTH > 32) begin : g_bad_cnt_width
      $fatal(1, "wb_pwm: CNT_WIDTH must be in [1,32]");
   end

   localparam int unsigned PRE_WIDTH  = 16;
   localparam logic [3:0]  IDX_CTRL   = 4'd0;
   localparam logic [3:0]  IDX_PRE    = 4'd1;
   localparam logic [3:0]  IDX_PERIOD = 4'd2;
   localparam int unsigned IDX_DUTY0  = 3;

   logic [3:0]           reg_idx;
   logic                 bus_req;
   logic                 wr;
   logic                 rd;
   logic                 ctrl_en;
   logic [PRE_WIDTH-1:0] prescale;
   logic [CNT_WIDTH-1:0] period_reg;
   logic [CNT_WIDTH-1:0] duty_reg [PORT_CNT];
   logic [CNT_WIDTH-1:0] period;
   logic [CNT_WIDTH-1:0] duty [PORT_CNT];
   logic [PRE_WIDTH-1:0] pre_cnt;
   logic [CNT_WIDTH-1:0] cnt;
   logic                 tick;
   logic                 wrap;
   logic [31:0]          rd_data;
   logic                 unused_bits;

   assign reg_idx     = wb.adr[5:2];
   assign bus_req     = wb.cyc && wb.stb;
   assign wr          = bus_req && wb.we;
   assign rd          = bus_req && !wb.we;
   assign wb.ack      = bus_req;
   assign wb.stall    = 1'b0;
   assign wb.dat_o    = rd_data;
   assign unused_bits = ^{wb.sel, wb.adr[31:6], wb.adr[1:0], wb.dat_i};

   // >= keeps the prescaler from running away if PRESCALE is lowered below the live count
   assign tick = ctrl_en && (pre_cnt >= prescale);
   assign wrap = tick && (cnt >= period);

   // Programmed register file (active registers, or shadows when double-buffered)
   always_ff @(posedge wb.clk_i) begin
      if (wb.rst_i) begin
         ctrl_en    <= 1'b0;
         prescale   <= '0;
         period_reg <= '0;
         for (int i = 0; i < int'(PORT_CNT); i++) duty_reg[i] <= '0;
      end else if (wr) begin
         if (reg_idx == IDX_CTRL)   ctrl_en    <= wb.dat_i[0];
         if (reg_idx == IDX_PRE)    prescale   <= wb.dat_i[PRE_WIDTH-1:0];
         if (reg_idx == IDX_PERIOD) period_reg <= wb.dat_i[CNT_WIDTH-1:0];
         for (int i = 0; i < int'(PORT_CNT); i++) begin
            if (reg_idx == 4'(IDX_DUTY0 + i)) duty_reg[i] <= wb.dat_i[CNT_WIDTH-1:0];
         end
      end
   end

`ifdef WB_PWM_SHADOW_EN
   // Shadows load into the active set at the period wrap, or continuously while disabled
   always_ff @(posedge wb.clk_i) begin
      if (wb.rst_i) begin
         period <= '0;
         for (int i = 0; i < int'(PORT_CNT); i++) duty[i] <= '0;
      end else if (!ctrl_en || wrap) begin
         period <= period_reg;
         for (int i = 0; i < int'(PORT_CNT); i++) duty[i] <= duty_reg[i];
      end
   end
`else
   assign period = period_reg;
   assign duty   = duty_reg;
`endif

   always_ff @(posedge wb.clk_i) begin
      if (wb.rst_i || !ctrl_en) begin
         pre_cnt <= '0;
         cnt     <= '0;
      end else if (tick) begin
         pre_cnt <= '0;
         cnt     <= wrap ? '0 : cnt + CNT_WIDTH'(1);
      end else begin
         pre_cnt <= pre_cnt + PRE_WIDTH'(1);
      end
   end

   always_ff @(posedge wb.clk_i) begin
      if (wb.rst_i || !ctrl_en) begin
         pwm_out <= '0;
      end else begin
         for (int i = 0; i < int'(PORT_CNT); i++) pwm_out[i] <= (cnt < duty[i]);
      end
   end

   always_comb begin
      rd_data = '0;
      if (rd) begin
         if (reg_idx == IDX_CTRL)   rd_data = 32'(ctrl_en);
         if (reg_idx == IDX_PRE)    rd_data = 32'(prescale);
         if (reg_idx == IDX_PERIOD) rd_data = 32'(period_reg);
         for (int i = 0; i < int'(PORT_CNT); i++) begin
            if (reg_idx == 4'(IDX_DUTY0 + i)) rd_data = 32'(duty_reg[i]);
         end
      end
   end

endmodule
